// File: rtl/fht_ctrl_pkg.sv
// Shared types and helpers for the FHT address generator.
// Holds the controller state encoding, the configuration legality bounds
// and the bit-reverse helper used when FHT_BITREV_EN is defined.
package fht_ctrl_pkg;

  // Legal configuration range.
  localparam int N_LOG_MIN = 3;
  localparam int N_LOG_MAX = 16;
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fht_state_e;

  // Reverse the low n bits of v; bits at and above n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < n) r[b] = v[n-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Stall-aware shift register: a word entering on a non-stalled cycle
// appears at o_q exactly DEPTH non-stalled cycles later. While i_stall
// is high every stage keeps its value.
module fht_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_stall,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [DEPTH-1:0][W-1:0] r_pipe;

  // Shift one position per non-stalled cycle; reset flushes every stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe <= '0;
    end else if (!i_stall) begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fht_addr_gen.sv
// FHT butterfly address generator.
// Per stage s (half-size h = 2^s) it issues N/2 read pairs (i, i+h) with the
// twiddle index, then idles LAT cycles while the butterfly pipeline drains.
// Write addresses are the read addresses delayed LAT non-stalled cycles and
// ping-pong between bank A and bank B from stage to stage.
// Optional build macro FHT_BITREV_EN: stage-0 read (and hence write)
// addresses are bit-reversed, folding the input permutation into stage 0.
module fht_addr_gen
  import fht_ctrl_pkg::*;
#(
  parameter int N_LOG = 10,
  parameter int LAT   = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iSTALL,
  output logic [N_LOG-1:0] oADDR_RD_0,
  output logic [N_LOG-1:0] oADDR_RD_1,
  output logic             oRD_EN,
  output logic [N_LOG-1:0] oADDR_WR_0,
  output logic [N_LOG-1:0] oADDR_WR_1,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSRC_BANK,
  output logic [N_LOG-2:0] oADDR_COEF,
  output logic [4:0]       oSTAGE,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             oRDY,
  output logic             oDONE
);

  // Out-of-range latencies are pulled into the supported window.
  localparam int LAT_E = (LAT < LAT_MIN) ? LAT_MIN :
                         ((LAT > LAT_MAX) ? LAT_MAX : LAT);
  localparam int CW    = N_LOG - 1;             // read counter covers N/2 cycles
  localparam int DW    = 2 + 2 * N_LOG;         // delay line payload width
  localparam logic [4:0] LAST_STG = 5'(N_LOG - 1);
  localparam logic [4:0] LAST_DRN = 5'(LAT_E - 1);

  fht_state_e    r_state, w_state_nxt;
  logic [4:0]    r_stage, w_stage_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [4:0]    r_dcnt,  w_dcnt_nxt;
  logic          r_done,  w_done_nxt;

  logic          w_rd_act;
  logic          w_cnt_last;
  logic          w_drn_last;
  logic          w_stg_last;

  logic [N_LOG-1:0] w_c_ext;
  logic [N_LOG-1:0] w_lo_mask;
  logic [N_LOG-1:0] w_h;
  logic [N_LOG-1:0] w_i;
  logic [N_LOG-1:0] w_j;
  logic [N_LOG-1:0] w_rd0;
  logic [N_LOG-1:0] w_rd1;
  logic [N_LOG-1:0] w_rd0_g;
  logic [N_LOG-1:0] w_rd1_g;
  logic [CW-1:0]    w_k;
  logic [CW-1:0]    w_coef;

  logic [DW-1:0]    w_dl_in;
  logic [DW-1:0]    w_dl_out;
  logic             w_wr_en;
  logic             w_wr_bank;

  assign w_rd_act   = (r_state == ST_READ);
  assign w_cnt_last = (r_cnt == '1);
  assign w_drn_last = (r_dcnt == LAST_DRN);
  assign w_stg_last = (r_stage == LAST_STG);

  // ---------------------------------------------------------------------
  // Butterfly index arithmetic. With k = c mod h and g = c div h,
  // i = 2hg + k is c with a zero bit inserted at position s; j = i + h sets
  // that bit. Both stay below N because c < N/2.
  // ---------------------------------------------------------------------
  assign w_c_ext   = {1'b0, r_cnt};
  assign w_h       = N_LOG'(1) << r_stage;
  assign w_lo_mask = w_h - N_LOG'(1);
  assign w_i       = ((w_c_ext & ~w_lo_mask) << 1) | (w_c_ext & w_lo_mask);
  assign w_j       = w_i | w_h;

  // Twiddle index k * N/(2h) = k << (N_LOG-1-s); k < h keeps it in N_LOG-1 bits.
  assign w_k       = r_cnt & w_lo_mask[CW-1:0];
  assign w_coef    = w_k << (LAST_STG - r_stage);

`ifdef FHT_BITREV_EN
  assign w_rd0 = (r_stage == 5'd0) ? N_LOG'(bitrev(16'(w_i), N_LOG)) : w_i;
  assign w_rd1 = (r_stage == 5'd0) ? N_LOG'(bitrev(16'(w_j), N_LOG)) : w_j;
`else
  assign w_rd0 = w_i;
  assign w_rd1 = w_j;
`endif

  // Addresses are only meaningful while reading; elsewhere they sit at zero.
  assign w_rd0_g = w_rd_act ? w_rd0 : '0;
  assign w_rd1_g = w_rd_act ? w_rd1 : '0;

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------

  // State and counter registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic. A start is taken in IDLE even while stalled, so the
  // block leaves ready immediately and the first read waits for the stall
  // to clear. Everything else advances only on non-stalled cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    w_dcnt_nxt  = r_dcnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iSTART) begin
          w_state_nxt = ST_READ;
          w_stage_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_READ: begin
        if (!iSTALL) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_cnt_last) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = '0;
            w_dcnt_nxt  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!iSTALL) begin
          w_dcnt_nxt = r_dcnt + 5'd1;
          if (w_drn_last) begin
            w_dcnt_nxt = '0;
            if (w_stg_last) begin
              w_state_nxt = ST_IDLE;
              w_stage_nxt = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_READ;
              w_stage_nxt = r_stage + 5'd1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_stage_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Write side: read enable, source bank and both read addresses travel
  // through the delay line together, so each write lands in the bank
  // opposite to the one its operands came from.
  // ---------------------------------------------------------------------
  assign w_dl_in = {w_rd_act, r_stage[0], w_rd0_g, w_rd1_g};

  fht_delay_line #(
    .W     (DW),
    .DEPTH (LAT_E)
  ) u_dly (
    .i_clk   (iCLK),
    .i_rst_n (iRESET),
    .i_stall (iSTALL),
    .i_d     (w_dl_in),
    .o_q     (w_dl_out)
  );

  assign w_wr_en   = w_dl_out[DW-1];
  assign w_wr_bank = w_dl_out[DW-2];

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign oRD_EN     = w_rd_act & ~iSTALL;
  assign oADDR_RD_0 = w_rd0_g;
  assign oADDR_RD_1 = w_rd1_g;
  assign oADDR_COEF = w_rd_act ? w_coef : '0;
  assign oADDR_WR_0 = w_dl_out[2*N_LOG-1:N_LOG];
  assign oADDR_WR_1 = w_dl_out[N_LOG-1:0];
  assign oWE_A      = w_wr_en &  w_wr_bank & ~iSTALL;
  assign oWE_B      = w_wr_en & ~w_wr_bank & ~iSTALL;
  assign oSRC_BANK  = r_stage[0];
  assign oSTAGE     = r_stage;
  assign oST_ZERO   = (r_stage == 5'd0);
  assign oST_LAST   = w_stg_last;
  assign oRDY       = (r_state == ST_IDLE);
  assign oDONE      = r_done;

endmodule

// File: doc/fht_addr_gen.md
FHT_ADDR_GEN -- requirements
Module: fht_addr_gen

Interface
REQ-001 Parameter N_LOG, default 10, log2 of transform length N = 2^N_LOG (legal 3..16).
REQ-002 Parameter LAT, default 4, read-to-write butterfly pipeline latency in cycles (legal 1..16).
REQ-003 Clock and reset: one clock iCLK; reset iRESET is asynchronous, active-low.
REQ-004 iCLK  input  1  clock, all logic on rising edge.
REQ-005 iRESET  input  1  asynchronous active-low reset.
REQ-006 iSTART  input  1  start pulse, accepted only while oRDY=1.
REQ-007 iSTALL  input  1  freezes all progress while high.
REQ-008 oADDR_RD_0 / oADDR_RD_1  output  N_LOG each  butterfly pair read addresses (i, j).
REQ-009 oRD_EN  output  1  read addresses valid this cycle.
REQ-010 oADDR_WR_0 / oADDR_WR_1  output  N_LOG each  butterfly pair write addresses.
REQ-011 oWE_A / oWE_B  output  1 each  write enable to bank A / bank B.
REQ-012 oSRC_BANK  output  1  bank being read, 0 = A, 1 = B.
REQ-013 oADDR_COEF  output  N_LOG-1  twiddle coefficient index.
REQ-014 oSTAGE  output  5  current stage 0..N_LOG-1; oST_ZERO / oST_LAST  output  1 each  stage flags.
REQ-015 oRDY  output  1  idle, ready for iSTART; oDONE  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states IDLE, READ, DRAIN; IDLE->READ on iSTART; READ->DRAIN after N/2 read cycles; DRAIN->READ (stage+1) after LAT cycles unless last stage; DRAIN->IDLE after last stage.
REQ-017 iSTART sampled at edge t0 -> oRDY=0 and first read valid in cycle t0+1; iSTART while oRDY=0 ignored.
REQ-018 Stage s: half-size h=2^s, read cycle c in 0..N/2-1, k=c mod h, g=c div h; i=2hg+k, j=i+h; oADDR_COEF = k*(N/(2h)).
REQ-019 Write addresses/enable are the read addresses/oRD_EN delayed exactly LAT non-stalled cycles.
REQ-020 Even stages read A, write B (oWE_B); odd stages read B, write A (oWE_A); never both enables high.
REQ-021 Stage duration N/2+LAT cycles; last write in cycle t0+N_LOG*(N/2+LAT); oRDY=1 and oDONE=1 in the following cycle.
REQ-022 iSTALL=1: FSM, counters, delay line hold; oRD_EN, oWE_A, oWE_B forced 0; addresses hold value.
REQ-023 iSTART coincident with iSTALL in IDLE accepted; first read delayed until iSTALL low.
REQ-024 Address arithmetic N_LOG bits unsigned, no wrap beyond N-1 ever produced.

Reset
REQ-025 iRESET low, any state: FSM->IDLE, delay line cleared, oRDY=1, all other outputs 0, oST_ZERO=1 (stage 0).
REQ-026 Reset mid-conversion aborts without any further write enable; restart needs new iSTART.

Configuration
REQ-027 Macro FHT_BITREV_EN defined: stage-0 read and write addresses are N_LOG-bit bit-reversed values of i and j.
REQ-028 FHT_BITREV_EN undefined: stage-0 addresses natural order per REQ-018; all other stages identical in both builds.

Structure
REQ-029 Package fht_ctrl_pkg holds state enum type, bit-reverse function, LAT/N_LOG legality constants.
REQ-030 Sub-module fht_delay_line (width, depth parameters, stall-aware shift register) implements REQ-019.

Verification
REQ-031 N_LOG=3, LAT=2, natural: reads stage0 (0,1)(2,3)(4,5)(6,7), stage1 (0,2)(1,3)(4,6)(5,7), stage2 (0,4)(1,5)(2,6)(3,7); coef 0,0,0,0 / 0,2,0,2 / 0,1,2,3.
REQ-032 Same config: iSTART at t0 -> oRDY=1, oDONE pulse at t0+19; writes equal reads shifted 2 cycles; oWE_B in stage 0/2, oWE_A in stage 1.
REQ-033 FHT_BITREV_EN, N_LOG=3: stage-0 reads (0,4)(2,6)(1,5)(3,7); stages 1-2 unchanged.
REQ-034 iSTALL high 3 cycles mid stage 1 -> no enables during stall, sequence resumes unchanged, oDONE at t0+22.
REQ-035 iRESET low in stage 1 -> outputs to reset values immediately, no writes; iSTART in stage 1 with reset inactive ignored.
REQ-036 N_LOG=10, LAT=4 against Matlab address files: zero mismatches, oDONE at t0+10*516+1.
